// File: rtl/iserdes_period_meter.sv
// iserdes_period_meter
//
// Purpose: locates the first qualifying edge in each deserialised sample word
// to 1/IN_WIDTH-cycle resolution and measures the distance between
// consecutive accepted edges as a period in sub-cycle units.
// Stage 1 finds and registers the edge. Stage 2 is an IDLE/RUN machine that
// accumulates the elapsed units and emits periods or a timeout.
//
// Ports:
//   CLK           parallel-word clock, rising edge
//   RESETN        asynchronous active-low reset
//   IN            sample word, bit 0 is the earliest sample
//   CHANGED_FLAG  qualifying edge found in the previous word
//   CHANGED_BIT   position of the first qualifying edge in that word (0 if none)
//   PERIOD_VALID  one-cycle strobe, PERIOD_OUT carries a new period
//   PERIOD_OUT    distance between the last two accepted edges, held between strobes
//   TIMEOUT       level, no accepted edge within 2^PERIOD_BITS units
//   dbg_state     current stage-2 state (0 = IDLE, 1 = RUN)
//
// Handshake: PERIOD_VALID is a valid-only strobe with no ready. The
// consumer must take PERIOD_OUT in the same cycle that PERIOD_VALID is high.
//
// Optional feature: define ISERDES_PERIOD_GLITCH_REJECT_EN to reject edges
// closer than MIN_PERIOD units to the previous accepted edge while in RUN.
module iserdes_period_meter #(
    parameter int IN_WIDTH    = 8,
    parameter int PERIOD_BITS = 16,
    parameter int EDGE_MODE   = 0,
    parameter int MIN_PERIOD  = 16
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [IN_WIDTH-1:0]          IN,
    output logic                         CHANGED_FLAG,
    output logic [$clog2(IN_WIDTH)-1:0]  CHANGED_BIT,
    output logic                         PERIOD_VALID,
    output logic [PERIOD_BITS-1:0]       PERIOD_OUT,
    output logic                         TIMEOUT,
    output logic                         dbg_state
);

    localparam int KW    = $clog2(IN_WIDTH);
    localparam int ACC_W = PERIOD_BITS + 1;
    localparam logic [ACC_W-1:0] MIN_UNITS = ACC_W'(MIN_PERIOD);
`ifdef ISERDES_PERIOD_GLITCH_REJECT_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ---------------- stage 1: edge location ----------------
    logic [IN_WIDTH-1:0] pred;
    logic [IN_WIDTH-1:0] qual;
    logic [KW-1:0]       edge_k;
    logic                last_q, last_d;
    logic                changed_flag_q, changed_flag_d;
    logic [KW-1:0]       changed_bit_q, changed_bit_d;

    always_comb begin
        // Each sample's predecessor; bit 0 looks back at the previous word's MSB.
        pred = {IN[IN_WIDTH-2:0], last_q};
        case (EDGE_MODE)
            0:       qual = IN & ~pred;
            1:       qual = ~IN & pred;
            default: qual = IN ^ pred;
        endcase
        // Scan downward so the lowest qualifying position is the last write.
        edge_k = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (qual[i]) edge_k = KW'(i);
        end
        changed_flag_d = |qual;
        changed_bit_d  = edge_k;
        last_d         = IN[IN_WIDTH-1];
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            last_q         <= 1'b0;
            changed_flag_q <= 1'b0;
            changed_bit_q  <= '0;
        end else begin
            last_q         <= last_d;
            changed_flag_q <= changed_flag_d;
            changed_bit_q  <= changed_bit_d;
        end
    end

    // ---------------- stage 2: period measurement ----------------
    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   timeout_q, timeout_d;
    logic [ACC_W-1:0]       sum_edge, sum_word, edge_start;
    logic                   sat_edge, sat_word, glitch, edge_ok;

    // acc counts units from the last accepted edge to the end of the last word,
    // so acc + k is the edge-to-edge distance. The extra top bit flags >= 2^PERIOD_BITS.
    always_comb begin
        sum_edge   = acc_q + ACC_W'(changed_bit_q);
        sum_word   = acc_q + ACC_W'(IN_WIDTH);
        edge_start = ACC_W'(IN_WIDTH) - ACC_W'(changed_bit_q);
        sat_edge   = sum_edge[PERIOD_BITS];
        sat_word   = sum_word[PERIOD_BITS];
        glitch     = GLITCH_EN && (sum_edge < MIN_UNITS);
        edge_ok    = changed_flag_q && !glitch;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (changed_flag_q) state_d = S_RUN;
            S_RUN: begin
                if (edge_ok) begin
                    if (sat_edge) state_d = S_IDLE;
                end else if (sat_word) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d          = acc_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        timeout_d      = timeout_q;
        case (state_q)
            S_IDLE: begin
                // The arming edge clears a pending timeout but emits nothing.
                if (changed_flag_q) begin
                    acc_d     = edge_start;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                if (edge_ok) begin
                    if (!sat_edge) begin
                        period_valid_d = 1'b1;
                        period_d       = sum_edge[PERIOD_BITS-1:0];
                        acc_d          = edge_start;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else if (sat_word) begin
                    timeout_d = 1'b1;
                end else begin
                    acc_d = sum_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            acc_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign CHANGED_FLAG = changed_flag_q;
    assign CHANGED_BIT  = changed_bit_q;
    assign PERIOD_VALID = period_valid_q;
    assign PERIOD_OUT   = period_q;
    assign TIMEOUT      = timeout_q;
    assign dbg_state    = (state_q == S_RUN);

endmodule

// File: tb/tb_iserdes_period_meter.sv
// Bench for iserdes_period_meter. Four instances share one input stream:
//   0: rising edges, 16-bit period
//   1: both edges,   16-bit period
//   2: rising edges,  8-bit period (reaches timeout quickly)
//   3: falling edges, 8-bit period
// The reference model tracks absolute edge timestamps (word index * 8 + bit)
// and derives periods and timeouts from timestamp differences.
module tb_iserdes_period_meter;

    localparam int W  = 8;
    localparam int NI = 4;
    localparam int MODE_A [NI] = '{0, 2, 0, 1};
    localparam int PB_A   [NI] = '{16, 16, 8, 8};
    localparam longint MIN_P = 16;
`ifdef ISERDES_PERIOD_GLITCH_REJECT_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       CLK;
    logic       RESETN;
    logic [7:0] in_w;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- DUTs ----------------
    logic        f0, f1, f2, f3;
    logic [2:0]  b0, b1, b2, b3;
    logic        v0, v1, v2, v3;
    logic [15:0] p0, p1;
    logic [7:0]  p2, p3;
    logic        t0, t1, t2, t3;
    logic        d0, d1, d2, d3;

    iserdes_period_meter #(.IN_WIDTH(8), .PERIOD_BITS(16), .EDGE_MODE(0), .MIN_PERIOD(16)) u_dut0 (
        .CLK(CLK), .RESETN(RESETN), .IN(in_w), .CHANGED_FLAG(f0), .CHANGED_BIT(b0),
        .PERIOD_VALID(v0), .PERIOD_OUT(p0), .TIMEOUT(t0), .dbg_state(d0));
    iserdes_period_meter #(.IN_WIDTH(8), .PERIOD_BITS(16), .EDGE_MODE(2), .MIN_PERIOD(16)) u_dut1 (
        .CLK(CLK), .RESETN(RESETN), .IN(in_w), .CHANGED_FLAG(f1), .CHANGED_BIT(b1),
        .PERIOD_VALID(v1), .PERIOD_OUT(p1), .TIMEOUT(t1), .dbg_state(d1));
    iserdes_period_meter #(.IN_WIDTH(8), .PERIOD_BITS(8), .EDGE_MODE(0), .MIN_PERIOD(16)) u_dut2 (
        .CLK(CLK), .RESETN(RESETN), .IN(in_w), .CHANGED_FLAG(f2), .CHANGED_BIT(b2),
        .PERIOD_VALID(v2), .PERIOD_OUT(p2), .TIMEOUT(t2), .dbg_state(d2));
    iserdes_period_meter #(.IN_WIDTH(8), .PERIOD_BITS(8), .EDGE_MODE(1), .MIN_PERIOD(16)) u_dut3 (
        .CLK(CLK), .RESETN(RESETN), .IN(in_w), .CHANGED_FLAG(f3), .CHANGED_BIT(b3),
        .PERIOD_VALID(v3), .PERIOD_OUT(p3), .TIMEOUT(t3), .dbg_state(d3));

    // ---------------- reference model ----------------
    bit     m_last  [NI];
    bit     m_armed [NI];
    bit     m_tmo   [NI];
    longint m_tlast [NI];
    longint m_pout  [NI];
    bit     e_flag  [NI];
    int     e_k     [NI];
    bit     e_valid [NI];
    bit     pend_flag [NI];
    int     pend_k    [NI];
    longint pend_n;
    longint word_n;

    int n_checks;
    int n_fail;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_last[i] = 0; m_armed[i] = 0; m_tmo[i] = 0;
            m_tlast[i] = 0; m_pout[i] = 0;
            e_flag[i] = 0; e_k[i] = 0; e_valid[i] = 0;
            pend_flag[i] = 0; pend_k[i] = 0;
        end
        pend_n = 0;
    endtask

    // First qualifying sample position in a word, given the previous sample.
    task automatic model_s1(input int i, input logic [7:0] w);
        bit prev;
        bit q;
        prev = m_last[i];
        e_flag[i] = 0;
        e_k[i] = 0;
        for (int k = 0; k < W; k++) begin
            case (MODE_A[i])
                0:       q = w[k] && !prev;
                1:       q = !w[k] && prev;
                default: q = w[k] != prev;
            endcase
            if (q && !e_flag[i]) begin
                e_flag[i] = 1;
                e_k[i] = k;
            end
            prev = w[k];
        end
        m_last[i] = w[7];
    endtask

    // Period bookkeeping on the word seen one cycle earlier, in timestamps.
    task automatic model_s2(input int i);
        longint t, span, lim, elapsed;
        bit edge_ok;
        e_valid[i] = 0;
        lim = longint'(1) << PB_A[i];
        t = pend_n * W + pend_k[i];
        elapsed = (pend_n + 1) * W - m_tlast[i];
        if (!m_armed[i]) begin
            if (pend_flag[i]) begin
                m_armed[i] = 1;
                m_tlast[i] = t;
                m_tmo[i] = 0;
            end
        end else begin
            span = t - m_tlast[i];
            edge_ok = pend_flag[i] && !(GLITCH && span < MIN_P);
            if (edge_ok) begin
                if (span < lim) begin
                    e_valid[i] = 1;
                    m_pout[i] = span;
                    m_tlast[i] = t;
                end else begin
                    m_armed[i] = 0;
                    m_tmo[i] = 1;
                end
            end else if (elapsed >= lim) begin
                m_armed[i] = 0;
                m_tmo[i] = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        of, ov, ot, od;
        logic [2:0]  ob;
        logic [15:0] op;
        for (int i = 0; i < NI; i++) begin
            case (i)
                0:       begin of = f0; ob = b0; ov = v0; op = p0;          ot = t0; od = d0; end
                1:       begin of = f1; ob = b1; ov = v1; op = p1;          ot = t1; od = d1; end
                2:       begin of = f2; ob = b2; ov = v2; op = {8'd0, p2}; ot = t2; od = d2; end
                default: begin of = f3; ob = b3; ov = v3; op = {8'd0, p3}; ot = t3; od = d3; end
            endcase
            chk($sformatf("dut%0d w%0d CHANGED_FLAG", i, word_n), 32'(of), 32'(e_flag[i]));
            chk($sformatf("dut%0d w%0d CHANGED_BIT", i, word_n),  32'(ob), 32'(e_k[i]));
            chk($sformatf("dut%0d w%0d PERIOD_VALID", i, word_n), 32'(ov), 32'(e_valid[i]));
            chk($sformatf("dut%0d w%0d PERIOD_OUT", i, word_n),   32'(op), 32'(m_pout[i]));
            chk($sformatf("dut%0d w%0d TIMEOUT", i, word_n),      32'(ot), 32'(m_tmo[i]));
            chk($sformatf("dut%0d w%0d state", i, word_n),        32'(od), 32'(m_armed[i]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic [7:0] w);
        in_w = w;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            model_s2(i);
            model_s1(i, w);
            pend_flag[i] = e_flag[i];
            pend_k[i] = e_k[i];
        end
        pend_n = word_n;
        word_n++;
        check_all();
    endtask

    // Square wave on the absolute sample timeline: high for h of every p units.
    task automatic run_wave(input int p, input int h, input int nw);
        logic [7:0] w;
        longint t;
        for (int n = 0; n < nw; n++) begin
            for (int k = 0; k < W; k++) begin
                t = word_n * W + k;
                w[k] = (t % p) < h;
            end
            step(w);
        end
    endtask

    // Two-unit pulses whose rising edges are spaced 20, 5, 20, 20 units apart.
    task automatic run_pulses(input int nw);
        int rises [5];
        logic [7:0] w;
        longint base, t;
        rises = '{4, 24, 29, 49, 69};
        base = word_n * W;
        for (int n = 0; n < nw; n++) begin
            for (int k = 0; k < W; k++) begin
                t = word_n * W + k - base;
                w[k] = 1'b0;
                for (int r = 0; r < 5; r++) begin
                    if (t >= rises[r] && t < rises[r] + 2) w[k] = 1'b1;
                end
            end
            step(w);
        end
    endtask

    task automatic mid_reset();
        RESETN = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        RESETN = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p, h;
        n_checks = 0;
        n_fail = 0;
        word_n = 0;
        RESETN = 1'b0;
        in_w = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        RESETN = 1'b1;

        // Single period from the directed word sequence.
        step(8'h00);
        step(8'hF8);
        step(8'hFF);
        step(8'h00);
        step(8'h80);
        step(8'h00);
        step(8'h00);

        // 20-unit square wave, 10 high / 10 low.
        run_wave(20, 10, 27);

        // Close edges for the glitch filter.
        run_pulses(11);

        // Arm, then starve the 8-bit instances into timeout, then recover.
        step(8'h00);
        step(8'hF0);
        for (int n = 0; n < 40; n++) step(8'h00);
        run_wave(20, 10, 8);

        // Reset in the middle of RUN; the first edge afterwards only re-arms.
        run_wave(20, 10, 6);
        mid_reset();
        run_wave(20, 10, 8);

        // Random square waves.
        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(120, 6);
            h = $urandom_range(p - 1, 1);
            run_wave(p, h, 20);
        end

        // Dense random words.
        for (int n = 0; n < 60; n++) step(8'($urandom_range(255, 0)));

        // Sparse random words with long quiet stretches.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(7, 0) == 0) step(8'($urandom_range(255, 0)));
            else step(8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
